// File: rtl/mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the cache-line-to-word memory bridge.
//   - FSM state encoding
//   - Burst geometry (BEATS, BEAT_W)
//   - Default parameter values, including the default beat-ack timeout used
//     when the bridge is built with MEM_BRIDGE_TIMEOUT_EN defined
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bridge_pkg;

    localparam int LINE_W_DEF         = 256;
    localparam int WORD_W_DEF         = 32;
    localparam int ADDR_W_DEF         = 28;
    localparam int BEATS              = 8;
    localparam int BEAT_W             = 3;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_READ_BURST  = 2'b01,
        ST_WRITE_BURST = 2'b10,
        ST_DONE        = 2'b11
    } state_e;

    // Beat index of the following beat; wraps from the last beat back to 0.
    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] beat);
        return beat + 3'd1;
    endfunction

endpackage

// File: rtl/mem_line_bridge_if.sv
// -----------------------------------------------------------------------------
// mem_line_bridge_if
// Bundles the controller-side line handshake and the external word bus.
//   line_addr/line_wr/line_rw/line_valid : line request from the controller
//   line_rd/line_ready/line_err          : line completion to the controller
//   ext_addr/ext_wdata/ext_we/ext_req    : beat request to external memory
//   ext_rdata/ext_ack                    : beat completion from external memory
// Modports:
//   slave  - the bridge itself
//   master - the environment (controller + memory) driving the bridge
// -----------------------------------------------------------------------------
interface mem_line_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0]        line_addr;
    logic [LINE_W-1:0]        line_wr;
    logic                     line_rw;
    logic                     line_valid;
    logic [LINE_W-1:0]        line_rd;
    logic                     line_ready;
    logic                     line_err;
    logic [ADDR_W+BEAT_W-1:0] ext_addr;
    logic [WORD_W-1:0]        ext_wdata;
    logic                     ext_we;
    logic                     ext_req;
    logic [WORD_W-1:0]        ext_rdata;
    logic                     ext_ack;

    modport slave (
        input  line_addr, line_wr, line_rw, line_valid,
        output line_rd, line_ready, line_err,
        output ext_addr, ext_wdata, ext_we, ext_req,
        input  ext_rdata, ext_ack
    );

    modport master (
        output line_addr, line_wr, line_rw, line_valid,
        input  line_rd, line_ready, line_err,
        input  ext_addr, ext_wdata, ext_we, ext_req,
        output ext_rdata, ext_ack
    );

endinterface

// File: rtl/mem_beat_buffer.sv
// -----------------------------------------------------------------------------
// mem_beat_buffer
// One LINE_W register shared by read assembly and write serialisation.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load_en     : load the whole line from load_line (has priority)
//   load_line   : line to load
//   wr_en       : write wr_word into slot wr_beat
//   wr_beat     : slot index, slot 0 = bits [WORD_W-1:0]
//   wr_word     : word written into the slot
//   rd_beat     : slot index for rd_word
//   rd_word     : current content of slot rd_beat
//   line_nxt    : value the register takes at the next edge; lets the owner
//                 capture a line that includes the word written this cycle
// -----------------------------------------------------------------------------
module mem_beat_buffer
    import mem_bridge_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int SLOT_W = BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_line,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_beat,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [SLOT_W-1:0] rd_beat,
    output logic [WORD_W-1:0] rd_word,
    output logic [LINE_W-1:0] line_nxt
);

    logic [LINE_W-1:0] line_r;

    // Next line value: whole-line load wins over a single-slot write.
    always_comb begin
        line_nxt = line_r;
        if (load_en) begin
            line_nxt = load_line;
        end else if (wr_en) begin
            line_nxt[wr_beat*WORD_W +: WORD_W] = wr_word;
        end else begin
            line_nxt = line_r;
        end
    end

    // Line storage register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_r <= '0;
        end else begin
            line_r <= line_nxt;
        end
    end

    assign rd_word = line_r[rd_beat*WORD_W +: WORD_W];

endmodule

// File: rtl/mem_line_bridge.sv
// -----------------------------------------------------------------------------
// mem_line_bridge
// Performs each 256-bit line read/write request as an 8-beat, 32-bit burst on
// the external word bus and completes it with a one-cycle line_ready pulse.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_line_bridge_if.slave (line handshake + external word bus)
// Build option:
//   MEM_BRIDGE_TIMEOUT_EN - when defined, a beat left unacknowledged for
//   TIMEOUT_CYCLES cycles aborts the burst with line_ready=1, line_err=1.
//   When undefined the bridge waits forever and line_err stays 0.
// All outputs are driven from registers.
// -----------------------------------------------------------------------------
module mem_line_bridge
    import mem_bridge_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_line_bridge_if.slave bus
);

    localparam int EXT_AW = ADDR_W + BEAT_W;

    state_e              state_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LINE_W-1:0]   line_rd_r;
    logic                line_ready_r;
    logic                line_err_r;
    logic                ext_req_r;
    logic                ext_we_r;
    logic [EXT_AW-1:0]   ext_addr_r;
    logic [WORD_W-1:0]   ext_wdata_r;

    logic                buf_load_s;
    logic                buf_wr_s;
    logic                last_beat_s;
    logic [BEAT_W-1:0]   beat_nxt_s;
    logic [WORD_W-1:0]   buf_rd_word_s;
    logic [LINE_W-1:0]   buf_line_nxt_s;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_CNT_W-1:0] to_cnt_r;
`endif

    // Buffer control: load on accept, fill slot `beat` on each read ack.
    always_comb begin
        buf_load_s  = (state_r == ST_IDLE) && bus.line_valid;
        buf_wr_s    = (state_r == ST_READ_BURST) && bus.ext_ack;
        beat_nxt_s  = next_beat(beat_r);
        last_beat_s = (beat_r == BEAT_W'(BEATS - 1));
    end

    // Reads fill slot `beat` while slot `beat+1` still holds the latched
    // write line, so the next ext_wdata is always the latched line word.
    mem_beat_buffer #(
        .LINE_W (LINE_W),
        .WORD_W (WORD_W),
        .SLOT_W (BEAT_W)
    ) u_beat_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (buf_load_s),
        .load_line (bus.line_wr),
        .wr_en     (buf_wr_s),
        .wr_beat   (beat_r),
        .wr_word   (bus.ext_rdata),
        .rd_beat   (beat_nxt_s),
        .rd_word   (buf_rd_word_s),
        .line_nxt  (buf_line_nxt_s)
    );

    // Bridge FSM, beat counter, ack timeout and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            addr_r       <= '0;
            line_rd_r    <= '0;
            line_ready_r <= 1'b0;
            line_err_r   <= 1'b0;
            ext_req_r    <= 1'b0;
            ext_we_r     <= 1'b0;
            ext_addr_r   <= '0;
            ext_wdata_r  <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            to_cnt_r     <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    line_ready_r <= 1'b0;
                    line_err_r   <= 1'b0;
                    if (bus.line_valid) begin
                        addr_r      <= bus.line_addr;
                        beat_r      <= '0;
                        ext_req_r   <= 1'b1;
                        ext_we_r    <= bus.line_rw;
                        ext_addr_r  <= {bus.line_addr, {BEAT_W{1'b0}}};
                        ext_wdata_r <= bus.line_wr[WORD_W-1:0];
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        to_cnt_r    <= '0;
`endif
                        state_r     <= bus.line_rw ? ST_WRITE_BURST : ST_READ_BURST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_READ_BURST, ST_WRITE_BURST: begin
                    if (bus.ext_ack) begin
                        beat_r <= beat_nxt_s;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        to_cnt_r <= '0;
`endif
                        if (last_beat_s) begin
                            state_r      <= ST_DONE;
                            ext_req_r    <= 1'b0;
                            line_ready_r <= 1'b1;
                            // Capture includes the final word landing this edge.
                            if (state_r == ST_READ_BURST) begin
                                line_rd_r <= buf_line_nxt_s;
                            end else begin
                                line_rd_r <= line_rd_r;
                            end
                        end else begin
                            ext_addr_r  <= {addr_r, beat_nxt_s};
                            ext_wdata_r <= buf_rd_word_s;
                        end
                    end
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    else if (to_cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: partial read data never reaches line_rd.
                        state_r      <= ST_DONE;
                        beat_r       <= '0;
                        to_cnt_r     <= '0;
                        ext_req_r    <= 1'b0;
                        line_ready_r <= 1'b1;
                        line_err_r   <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= state_r;
                    end
`endif
                end

                ST_DONE: begin
                    // line_valid deliberately ignored here.
                    line_ready_r <= 1'b0;
                    line_err_r   <= 1'b0;
                    state_r      <= ST_IDLE;
                end

                default: begin
                    state_r      <= ST_IDLE;
                    beat_r       <= '0;
                    line_ready_r <= 1'b0;
                    line_err_r   <= 1'b0;
                    ext_req_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.line_rd    = line_rd_r;
    assign bus.line_ready = line_ready_r;
    assign bus.line_err   = line_err_r;
    assign bus.ext_req    = ext_req_r;
    assign bus.ext_we     = ext_we_r;
    assign bus.ext_addr   = ext_addr_r;
    assign bus.ext_wdata  = ext_wdata_r;

endmodule

// File: tb/tb_mem_line_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_line_bridge
// Self-checking bench: acts as the cache controller and as a word-wide
// external memory (associative array of words), and predicts each burst from
// the line/beat address arithmetic and the wait schedule it applies.
// -----------------------------------------------------------------------------
module tb_mem_line_bridge;
    import mem_bridge_pkg::*;

    localparam int LW = 256;
    localparam int WW = 32;
    localparam int AW = 28;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_line_bridge_if #(.LINE_W(LW), .WORD_W(WW), .ADDR_W(AW)) bus ();

    mem_line_bridge #(
        .LINE_W (LW),
        .WORD_W (WW),
        .ADDR_W (AW)
`ifdef MEM_BRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (4)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0]  mem [logic [30:0]];
    logic [255:0] last_rd = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [30:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_line_rd"},    bus.line_rd,    256'd0);
        chk({tag, "_line_ready"}, bus.line_ready, 256'd0);
        chk({tag, "_line_err"},   bus.line_err,   256'd0);
        chk({tag, "_ext_req"},    bus.ext_req,    256'd0);
        chk({tag, "_ext_we"},     bus.ext_we,     256'd0);
        chk({tag, "_ext_addr"},   bus.ext_addr,   256'd0);
        chk({tag, "_ext_wdata"},  bus.ext_wdata,  256'd0);
    endtask

    // Starts just after a negedge with the bridge idle; returns just after a
    // negedge with the bridge idle. Period n = clock period ending at edge E+n.
    task automatic run_txn(input logic [27:0] addr, input logic rw, input logic [255:0] wl,
                           input int wait_beat, input int wait_n, input int rst_beat,
                           input bit hold_valid, input logic [27:0] n_addr,
                           input logic n_rw, input logic [255:0] n_wl);
        int beat = 0;
        int waited = 0;
        bit done = 0;
        logic [255:0] exp_line = '0;
        logic [30:0]  wa;
        bus.line_addr  = addr;
        bus.line_rw    = rw;
        bus.line_wr    = wl;
        bus.line_valid = 1'b1;
        bus.ext_ack    = 1'b0;
        @(posedge clk);
        #1;
        if (hold_valid) begin
            bus.line_addr = n_addr;
            bus.line_rw   = n_rw;
            bus.line_wr   = n_wl;
        end else begin
            bus.line_valid = 1'b0;
            bus.line_addr  = 28'($urandom);
            bus.line_rw    = 1'($urandom);
            bus.line_wr    = rand_line();
        end
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            wa = {addr, 3'(beat)};
            if (beat == rst_beat) begin
                rst_n = 1'b0;
                bus.ext_ack = 1'b1;
                @(negedge clk);
                chk_reset_vals("mid_rst");
                rst_n = 1'b1;
                last_rd = '0;
                repeat (12) begin
                    bus.ext_ack = 1'($urandom);
                    @(negedge clk);
                    chk("rst_no_ready", bus.line_ready, 256'd0);
                    chk("rst_no_req", bus.ext_req, 256'd0);
                end
                bus.ext_ack = 1'b0;
                done = 1;
            end else if (beat < 8) begin
                chk("ext_req", bus.ext_req, 256'd1);
                chk("ext_addr", bus.ext_addr, 256'(wa));
                chk("ext_we", bus.ext_we, 256'(rw));
                chk("ext_wdata", bus.ext_wdata, 256'(wl[beat*32 +: 32]));
                chk("busy_ready", bus.line_ready, 256'd0);
                if (beat == wait_beat && waited < wait_n) begin
                    bus.ext_ack   = 1'b0;
                    bus.ext_rdata = $urandom;
                    waited++;
                end else begin
                    bus.ext_ack   = 1'b1;
                    bus.ext_rdata = mem_word(wa);
                    exp_line[beat*32 +: 32] = bus.ext_rdata;
                    beat++;
                end
            end else begin
                chk("line_ready", bus.line_ready, 256'd1);
                chk("ready_cycle", 256'(n), 256'(9 + wait_n));
                chk("line_err", bus.line_err, 256'd0);
                chk("done_req", bus.ext_req, 256'd0);
                if (!rw) last_rd = exp_line;
                chk("line_rd", bus.line_rd, last_rd);
                bus.ext_ack = 1'($urandom);
                @(negedge clk);
                chk("one_ready", bus.line_ready, 256'd0);
                chk("idle_req", bus.ext_req, 256'd0);
                bus.ext_ack = 1'b0;
                done = 1;
            end
        end
        chk("txn_bound", 256'(done), 256'd1);
    endtask

    initial begin
        logic [255:0] dir_rd;
        logic [255:0] dir_wr;
        logic [255:0] la;
        logic [255:0] lb;
        logic [27:0]  ra;
        logic [27:0]  rb;
        bus.line_addr  = '0;
        bus.line_wr    = '0;
        bus.line_rw    = 1'b0;
        bus.line_valid = 1'b0;
        bus.ext_rdata  = '0;
        bus.ext_ack    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read of line 0x10: words 0x11111111*(beat+1).
        for (int b = 0; b < 8; b++) begin
            mem[{28'h0000010, 3'(b)}] = 32'h11111111 * (b + 1);
            dir_rd[b*32 +: 32] = 32'h11111111 * (b + 1);
        end
        run_txn(28'h0000010, 1'b0, rand_line(), -1, 0, -1, 1'b0, '0, 1'b0, '0);
        chk("dir_read_line", bus.line_rd, dir_rd);

        // Zero-wait write of line 0 with words 0..7; line_rd untouched.
        for (int b = 0; b < 8; b++) dir_wr[b*32 +: 32] = 32'(b);
        run_txn(28'h0000000, 1'b1, dir_wr, -1, 0, -1, 1'b0, '0, 1'b0, '0);
        chk("write_keeps_rd", bus.line_rd, dir_rd);

        // Ack withheld 3 cycles on beat 2 (read, then write).
        run_txn(28'h00ABCDE, 1'b0, rand_line(), 2, 3, -1, 1'b0, '0, 1'b0, '0);
        run_txn(28'h0012345, 1'b1, rand_line(), 2, 3, -1, 1'b0, '0, 1'b0, '0);

        // line_valid held through DONE: back-to-back, next request pre-driven.
        ra = 28'($urandom);
        rb = 28'($urandom);
        la = rand_line();
        lb = rand_line();
        run_txn(ra, 1'b0, la, -1, 0, -1, 1'b1, rb, 1'b1, lb);
        run_txn(rb, 1'b1, lb, 5, 1, -1, 1'b1, ra, 1'b0, la);
        run_txn(ra, 1'b0, la, -1, 0, -1, 1'b0, '0, 1'b0, '0);

        // Reset at beat 4 of a read, then a normal read.
        run_txn(28'h0BEEF00, 1'b0, rand_line(), -1, 0, 4, 1'b0, '0, 1'b0, '0);
        run_txn(28'h0BEEF00, 1'b0, rand_line(), -1, 0, -1, 1'b0, '0, 1'b0, '0);

        // Ack never given.
        bus.line_addr  = 28'h0000777;
        bus.line_rw    = 1'b0;
        bus.line_valid = 1'b1;
        bus.ext_ack    = 1'b0;
        @(posedge clk);
        #1;
        bus.line_valid = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        repeat (4) begin
            @(negedge clk);
            chk("to_req", bus.ext_req, 256'd1);
            chk("to_no_ready", bus.line_ready, 256'd0);
        end
        @(negedge clk);
        chk("to_ready", bus.line_ready, 256'd1);
        chk("to_err", bus.line_err, 256'd1);
        chk("to_req_drop", bus.ext_req, 256'd0);
        chk("to_rd_kept", bus.line_rd, last_rd);
        @(negedge clk);
        chk("to_ready_end", bus.line_ready, 256'd0);
`else
        repeat (100) begin
            @(negedge clk);
            chk("hang_req", bus.ext_req, 256'd1);
            chk("hang_no_ready", bus.line_ready, 256'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        chk_reset_vals("hang_rst");
`endif

        // Randomized transactions with a random wait on a random beat.
        repeat (10) begin
            run_txn(28'($urandom), 1'($urandom), rand_line(), $urandom_range(0, 7),
                    $urandom_range(0, 3), -1, 1'b0, '0, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
